mem_access_stage: RTL and testbench

- Memory-access pipeline stage; the downstream end of the execute-stage output interface.
- Consumes the execute-stage bundle: aluop, write address, write data (the effective address for loads/stores), wreg/mreg/whilo flags, store data, 64-bit hilo.
- Drives a req/ack data-memory bus for LB/LW/SB/SW and stalls upstream while an access is in flight.
- Registers results toward write-back; non-memory instructions pass through with one cycle of latency.

---
 rtl/mem_access_stage.sv | 140 ++++++++++++++
 tb/tb_mem_access_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: drives a req/ack data bus for LB/LW/SB/SW,
// stalls upstream while an access is outstanding, and registers results toward write-back.
module mem_access_stage #(
  parameter int BUS_TIMEOUT = 255,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid_i,
  input  logic [7:0]  mem_aluop_i,
  input  logic [4:0]  mem_wa_i,
  input  logic [31:0] mem_wd_i,
  input  logic        mem_wreg_i,
  input  logic        mem_mreg_i,
  input  logic        mem_whilo_i,
  input  logic [31:0] mem_din_i,
  input  logic [63:0] mem_hilo_i,
  output logic        stall_o,
  output logic        dm_req_o,
  output logic        dm_we_o,
  output logic [3:0]  dm_be_o,
  output logic [31:0] dm_addr_o,
  output logic [31:0] dm_wdata_o,
  input  logic        dm_ack_i,
  input  logic [31:0] dm_rdata_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_wa_o,
  output logic        wb_wreg_o,
  output logic [31:0] wb_wd_o,
  output logic        wb_whilo_o,
  output logic [63:0] wb_hilo_o,
  output logic        align_err_o,
  output logic        bus_err_o
);
  localparam int CW = $clog2(BUS_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BUS_TIMEOUT - 1);

  typedef enum logic {IDLE, REQ} state_t;
  state_t state_q, state_d;

  logic [CW-1:0] cnt_q;
  logic [1:0]    k;
  logic          is_lb, is_lw, is_sb, is_sw, is_load, is_store;
  logic          mem_op, misalign, go, timeout;
  logic [7:0]    rbyte;
  logic [31:0]   ld_data;

  assign k        = mem_wd_i[1:0];
  assign is_lb    = (mem_aluop_i == 8'h90);
  assign is_lw    = (mem_aluop_i == 8'h92);
  assign is_sb    = (mem_aluop_i == 8'h98);
  assign is_sw    = (mem_aluop_i == 8'h9A);
  assign is_load  = (is_lb | is_lw) & mem_mreg_i;
  assign is_store = is_sb | is_sw;
  assign mem_op   = mem_valid_i & (is_load | is_store);
  assign misalign = ALIGN_CHECK & mem_op & (is_lw | is_sw) & (k != 2'b00);
  assign go       = (state_q == IDLE) & mem_op & ~misalign;
  // Fires on the cycle whose increment would reach BUS_TIMEOUT, so req is held BUS_TIMEOUT cycles.
  assign timeout  = (state_q == REQ) & ~dm_ack_i & (cnt_q == CNT_LAST);
  assign stall_o  = go | ((state_q == REQ) & ~dm_ack_i & ~timeout);

  // Upstream holds the bundle during REQ, so the live address still selects the byte.
  assign rbyte    = dm_rdata_i[{k, 3'b000} +: 8];
  assign ld_data  = is_lb ? {{24{rbyte[7]}}, rbyte} : dm_rdata_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go) state_d = REQ;
      default: if (dm_ack_i | timeout) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      dm_req_o    <= 1'b0;
      dm_we_o     <= 1'b0;
      dm_be_o     <= 4'b0;
      dm_addr_o   <= 32'b0;
      dm_wdata_o  <= 32'b0;
      wb_valid_o  <= 1'b0;
      wb_wa_o     <= 5'b0;
      wb_wreg_o   <= 1'b0;
      wb_wd_o     <= 32'b0;
      wb_whilo_o  <= 1'b0;
      wb_hilo_o   <= 64'b0;
      align_err_o <= 1'b0;
      bus_err_o   <= 1'b0;
    end else begin
      align_err_o <= 1'b0;
      bus_err_o   <= 1'b0;
      if (state_q == IDLE) begin
        if (go) begin
          dm_req_o   <= 1'b1;
          dm_we_o    <= is_store;
          dm_be_o    <= (is_lb | is_sb) ? (4'b0001 << k) : 4'b1111;
          dm_addr_o  <= {mem_wd_i[31:2], 2'b00};
          dm_wdata_o <= is_sb ? {4{mem_din_i[7:0]}} : mem_din_i;
          wb_valid_o <= 1'b0;
          cnt_q      <= '0;
        end else if (misalign) begin
          wb_valid_o  <= 1'b1;
          wb_wa_o     <= mem_wa_i;
          wb_wreg_o   <= 1'b0;
          wb_wd_o     <= 32'b0;
          wb_whilo_o  <= 1'b0;
          wb_hilo_o   <= mem_hilo_i;
          align_err_o <= 1'b1;
        end else begin
          wb_valid_o <= mem_valid_i;
          wb_wa_o    <= mem_wa_i;
          wb_wreg_o  <= mem_wreg_i;
          wb_wd_o    <= mem_wd_i;
          wb_whilo_o <= mem_whilo_i;
          wb_hilo_o  <= mem_hilo_i;
        end
      end else begin
        if (dm_ack_i | timeout) begin
          dm_req_o   <= 1'b0;
          wb_valid_o <= 1'b1;
          wb_wa_o    <= mem_wa_i;
          wb_whilo_o <= mem_whilo_i;
          wb_hilo_o  <= mem_hilo_i;
          wb_wreg_o  <= (dm_ack_i & is_load) ? mem_wreg_i : 1'b0;
          wb_wd_o    <= (dm_ack_i & is_load) ? ld_data : 32'b0;
          bus_err_o  <= ~dm_ack_i;
        end else begin
          cnt_q      <= cnt_q + CW'(1);
          wb_valid_o <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed vectors push expected write-back
// records; a monitor pops and compares whenever wb_valid_o is seen.
module tb_mem_access_stage;
  localparam int BUS_TO = 4;

  logic        clk, rst_n;
  logic        mem_valid_i, mem_wreg_i, mem_mreg_i, mem_whilo_i;
  logic [7:0]  mem_aluop_i;
  logic [4:0]  mem_wa_i;
  logic [31:0] mem_wd_i, mem_din_i;
  logic [63:0] mem_hilo_i;
  logic        stall_o, dm_req_o, dm_we_o, dm_ack_i;
  logic [3:0]  dm_be_o;
  logic [31:0] dm_addr_o, dm_wdata_o, dm_rdata_i;
  logic        wb_valid_o, wb_wreg_o, wb_whilo_o, align_err_o, bus_err_o;
  logic [4:0]  wb_wa_o;
  logic [31:0] wb_wd_o;
  logic [63:0] wb_hilo_o;

  mem_access_stage #(.BUS_TIMEOUT(BUS_TO), .ALIGN_CHECK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid_i(mem_valid_i), .mem_aluop_i(mem_aluop_i), .mem_wa_i(mem_wa_i),
    .mem_wd_i(mem_wd_i), .mem_wreg_i(mem_wreg_i), .mem_mreg_i(mem_mreg_i),
    .mem_whilo_i(mem_whilo_i), .mem_din_i(mem_din_i), .mem_hilo_i(mem_hilo_i),
    .stall_o(stall_o), .dm_req_o(dm_req_o), .dm_we_o(dm_we_o), .dm_be_o(dm_be_o),
    .dm_addr_o(dm_addr_o), .dm_wdata_o(dm_wdata_o), .dm_ack_i(dm_ack_i),
    .dm_rdata_i(dm_rdata_i), .wb_valid_o(wb_valid_o), .wb_wa_o(wb_wa_o),
    .wb_wreg_o(wb_wreg_o), .wb_wd_o(wb_wd_o), .wb_whilo_o(wb_whilo_o),
    .wb_hilo_o(wb_hilo_o), .align_err_o(align_err_o), .bus_err_o(bus_err_o)
  );

  typedef struct {
    logic [4:0]  wa;
    logic        wreg;
    logic [31:0] wd;
    logic        chk_wd;
    logic        whilo;
    logic [63:0] hilo;
    logic        aerr;
    logic        berr;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write-back beat must match the oldest expected record.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (wb_valid_o) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL wb_unexpected: got wb_valid_o=1 wd=%h expected no output", wb_wd_o);
        end else begin
          mon_e = sb_q.pop_front();
          check("wb_wa", 64'(wb_wa_o), 64'(mon_e.wa));
          check("wb_wreg", 64'(wb_wreg_o), 64'(mon_e.wreg));
          if (mon_e.chk_wd) check("wb_wd", 64'(wb_wd_o), 64'(mon_e.wd));
          check("wb_whilo", 64'(wb_whilo_o), 64'(mon_e.whilo));
          check("wb_hilo", wb_hilo_o, mon_e.hilo);
          check("align_err", 64'(align_err_o), 64'(mon_e.aerr));
          check("bus_err", 64'(bus_err_o), 64'(mon_e.berr));
        end
      end else if (align_err_o | bus_err_o) begin
        tests++;
        fails++;
        $display("FAIL err_stray: got aerr=%b berr=%b expected 0 without wb_valid_o", align_err_o, bus_err_o);
      end
    end
  end

  task automatic idle_inputs();
    mem_valid_i = 1'b0;
    mem_aluop_i = 8'h00;
    mem_mreg_i  = 1'b0;
    mem_whilo_i = 1'b0;
    mem_hilo_i  = 64'h0;
  endtask

  task automatic drive(input logic [7:0] op, input logic [31:0] wd, input logic [31:0] din,
                       input logic [4:0] wa, input logic wreg, input logic mreg,
                       input logic whilo, input logic [63:0] hilo);
    mem_valid_i = 1'b1;
    mem_aluop_i = op;
    mem_wd_i    = wd;
    mem_din_i   = din;
    mem_wa_i    = wa;
    mem_wreg_i  = wreg;
    mem_mreg_i  = mreg;
    mem_whilo_i = whilo;
    mem_hilo_i  = hilo;
  endtask

  task automatic do_pass(input logic [7:0] op, input logic [31:0] wd, input logic [4:0] wa,
                         input logic wreg, input logic mreg, input logic whilo, input logic [63:0] hilo);
    @(negedge clk);
    drive(op, wd, 32'h0, wa, wreg, mreg, whilo, hilo);
    sb_q.push_back('{wa: wa, wreg: wreg, wd: wd, chk_wd: 1'b1, whilo: whilo, hilo: hilo,
                     aerr: 1'b0, berr: 1'b0});
    #1;
    check("pass_stall", 64'(stall_o), 64'(0));
    check("pass_noreq", 64'(dm_req_o), 64'(0));
    @(negedge clk);
    idle_inputs();
  endtask

  // d = number of REQ cycles before ack; d < 0 means never ack (timeout).
  task automatic do_mem(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] din,
                        input logic [4:0] wa, input int d, input logic [31:0] rdata,
                        input logic [3:0] e_be, input logic e_we, input logic [31:0] e_wdata,
                        input logic [31:0] e_wd, input logic e_wreg, input logic e_berr);
    int n;
    logic ld;
    ld = (op == 8'h90) || (op == 8'h92);
    n  = (d < 0) ? BUS_TO : d + 1;
    @(negedge clk);
    drive(op, addr, din, wa, 1'b1, ld, 1'b0, 64'h0);
    sb_q.push_back('{wa: wa, wreg: e_wreg, wd: e_wd, chk_wd: !e_berr, whilo: 1'b0, hilo: 64'h0,
                     aerr: 1'b0, berr: e_berr});
    #1;
    check("issue_stall", 64'(stall_o), 64'(1));
    check("issue_noreq", 64'(dm_req_o), 64'(0));
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (d >= 0 && i == d) begin
        dm_ack_i   = 1'b1;
        dm_rdata_i = rdata;
      end
      #1;
      check("req_held", 64'(dm_req_o), 64'(1));
      check("req_be", 64'(dm_be_o), 64'(e_be));
      check("req_we", 64'(dm_we_o), 64'(e_we));
      check("req_addr", 64'(dm_addr_o), 64'(addr & 32'hFFFF_FFFC));
      if (e_we) check("req_wdata", 64'(dm_wdata_o), 64'(e_wdata));
      check("req_stall", 64'(stall_o), (i == n - 1) ? 64'(0) : 64'(1));
    end
    @(negedge clk);
    dm_ack_i   = 1'b0;
    dm_rdata_i = 32'hDEAD_0000;
    idle_inputs();
    #1;
    check("done_noreq", 64'(dm_req_o), 64'(0));
    check("done_stall", 64'(stall_o), 64'(0));
    check("done_berr", 64'(bus_err_o), 64'(e_berr));
    @(negedge clk);
    #1;
    check("berr_pulse_end", 64'(bus_err_o), 64'(0));
  endtask

  task automatic do_misalign(input logic [7:0] op, input logic [31:0] addr, input logic [4:0] wa);
    logic ld;
    ld = (op == 8'h92);
    @(negedge clk);
    drive(op, addr, 32'h5555_5555, wa, 1'b1, ld, 1'b0, 64'h0);
    sb_q.push_back('{wa: wa, wreg: 1'b0, wd: 32'h0, chk_wd: 1'b0, whilo: 1'b0, hilo: 64'h0,
                     aerr: 1'b1, berr: 1'b0});
    #1;
    check("mis_stall", 64'(stall_o), 64'(0));
    check("mis_noreq", 64'(dm_req_o), 64'(0));
    @(negedge clk);
    idle_inputs();
    #1;
    check("mis_noreq_after", 64'(dm_req_o), 64'(0));
    check("mis_aerr", 64'(align_err_o), 64'(1));
    @(negedge clk);
    #1;
    check("mis_aerr_end", 64'(align_err_o), 64'(0));
  endtask

  initial begin
    rst_n      = 1'b0;
    dm_ack_i   = 1'b0;
    dm_rdata_i = 32'h0;
    mem_wd_i   = 32'h0;
    mem_din_i  = 32'h0;
    mem_wa_i   = 5'd0;
    mem_wreg_i = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    #1;
    check("rst_wb_valid", 64'(wb_valid_o), 64'(0));
    check("rst_wb_wd", 64'(wb_wd_o), 64'(0));
    check("rst_dm_req", 64'(dm_req_o), 64'(0));
    check("rst_stall", 64'(stall_o), 64'(0));
    check("rst_errs", 64'({align_err_o, bus_err_o}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    do_pass(8'h19, 32'h0000_1234, 5'd5, 1'b1, 1'b0, 1'b0, 64'h0);
    do_pass(8'h2B, 32'h0000_0055, 5'd9, 1'b0, 1'b0, 1'b1, 64'h0123_4567_89AB_CDEF);
    do_pass(8'h21, 32'h0BAD_F00D, 5'd2, 1'b1, 1'b1, 1'b0, 64'h0);
    do_mem(8'h90, 32'h0000_0103, 32'h0, 5'd3, 0, 32'h80FF_1122,
           4'b1000, 1'b0, 32'h0, 32'hFFFF_FF80, 1'b1, 1'b0);
    do_mem(8'h90, 32'h0000_0101, 32'h0, 5'd4, 1, 32'h80FF_1122,
           4'b0010, 1'b0, 32'h0, 32'h0000_0011, 1'b1, 1'b0);
    do_mem(8'h98, 32'h0000_0202, 32'h0000_00A5, 5'd6, 3, 32'h0,
           4'b0100, 1'b1, 32'hA5A5_A5A5, 32'h0, 1'b0, 1'b0);
    do_mem(8'h92, 32'h0000_0104, 32'h0, 5'd7, 1, 32'hDEAD_BEEF,
           4'b1111, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b1, 1'b0);
    do_mem(8'h9A, 32'h0000_0208, 32'h1234_5678, 5'd8, 0, 32'h0,
           4'b1111, 1'b1, 32'h1234_5678, 32'h0, 1'b0, 1'b0);
    do_misalign(8'h92, 32'h0000_0006, 5'd10);
    do_misalign(8'h9A, 32'h0000_0003, 5'd11);
    do_mem(8'h92, 32'h0000_0040, 32'h0, 5'd12, -1, 32'h0,
           4'b1111, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // Reset in the middle of an access, then a stray ack.
    @(negedge clk);
    drive(8'h19, 32'h0000_CAFE, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 64'h0);
    sb_q.push_back('{wa: 5'd7, wreg: 1'b1, wd: 32'h0000_CAFE, chk_wd: 1'b1, whilo: 1'b0,
                     hilo: 64'h0, aerr: 1'b0, berr: 1'b0});
    @(negedge clk);
    drive(8'h9A, 32'h0000_0080, 32'h1111_2222, 5'd13, 1'b1, 1'b0, 1'b0, 64'h0);
    #1;
    check("rstmid_issue_stall", 64'(stall_o), 64'(1));
    @(negedge clk);
    #1;
    check("rstmid_req", 64'(dm_req_o), 64'(1));
    #2;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check("rstmid_dm_req", 64'(dm_req_o), 64'(0));
    check("rstmid_wb_valid", 64'(wb_valid_o), 64'(0));
    check("rstmid_wb_wd", 64'(wb_wd_o), 64'(0));
    check("rstmid_wb_wa", 64'(wb_wa_o), 64'(0));
    check("rstmid_wb_wreg", 64'(wb_wreg_o), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dm_ack_i   = 1'b1;
    dm_rdata_i = 32'hFFFF_FFFF;
    #1;
    check("late_ack_stall", 64'(stall_o), 64'(0));
    @(negedge clk);
    dm_ack_i = 1'b0;
    #1;
    check("late_ack_wb_valid", 64'(wb_valid_o), 64'(0));
    check("late_ack_dm_req", 64'(dm_req_o), 64'(0));

    repeat (3) @(negedge clk);
    check("sb_drained", 64'(sb_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
